wb_write_queue: RTL and testbench
=================================

Name: wb_write_queue

Overview:
- Writer-side front end for the 32x32 register file write port (wn, d, we).
- Buffers results from long-latency units (load miss, multiply/divide) in a small FIFO of pending register writes.
- Drains the FIFO into the register file whenever the main pipeline's writeback slot is idle.
- Provides two lookup ports so decode can forward from, or stall on, writes that are still pending.

Parameters:
DEPTH, 4, number of pending-write entries (power of two, 2..16)
AW, 2, log2(DEPTH), pointer width

Ports:
clk  in  1  clock; all state updates on posedge
clrn  in  1  asynchronous active-low reset
enq_we  in  1  long-latency result valid this cycle
enq_wn  in  5  destination register of enqueued result
enq_d  in  32  enqueued result data
enq_ready  out  1  queue can accept (not full)
pipe_we  in  1  main pipeline writeback this cycle (has priority)
pipe_wn  in  5  main pipeline destination register
pipe_d  in  32  main pipeline writeback data
we  out  1  register file write enable
wn  out  5  register file write register
d  out  32  register file write data
rna  in  5  lookup register A (decode read port A)
rnb  in  5  lookup register B (decode read port B)
hit_a  out  1  a valid pending write targets rna
qa_fwd  out  32  data of youngest valid pending write to rna
hit_b  out  1  same for rnb
qb_fwd  out  32  same for rnb
count  out  AW+1  number of occupied entries

Behaviour:
- Storage: each entry holds valid(1), wn(5), d(32). Head and tail pointers wrap modulo DEPTH. count is 0..DEPTH.
- Reset (clrn=0, asynchronous): head=tail=0, count=0, all valid bits 0. Outputs during reset: enq_ready=1, hit_a=hit_b=0, qa_fwd=qb_fwd=0, count=0. We/wn/d follow pipe_* combinationally.
- Enqueue at posedge:
  - Occurs if enq_we=1, enq_ready=1 and enq_wn!=0. Entry written at tail with valid=1; tail++.
  - If enq_wn=0, the write is discarded and no entry is allocated.
  - If enq_we=1 while full, the push is dropped; the producer must hold until enq_ready=1.
- enq_ready = (count != DEPTH), combinational from state only; it does not depend on a same-cycle pop.
- Write-port mux (combinational):
  - If pipe_we=1: we=1, wn=pipe_wn, d=pipe_d.
  - Else if count!=0: we=head.valid, wn=head.wn, d=head.d.
  - Else: we=0, wn=0, d=0.
- Dequeue:
  - When pipe_we=0 and count!=0, the head retires at posedge (head++), whether valid or killed.
  - The register file samples on the following negedge within the same cycle; the queue itself adds zero latency.
- Kill rule (write-after-write ordering):
  - Queued entries are older than the pipe write.
  - When pipe_we=1 and pipe_wn!=0, at posedge every occupied entry with wn==pipe_wn gets valid=0.
  - Killed entries still occupy a slot and drain later with we=0.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle: count unchanged.
  - Enqueue and kill of the same register in the same cycle: the kill applies to existing entries only; the new entry stays valid.
- Lookup (combinational):
  - hit_a=1 iff rna!=0 and some occupied valid entry has wn==rna.
  - qa_fwd = data of the youngest such entry (closest to tail); 0 when no hit.
  - Port B is identical. Lookup does not include the current enq_* or pipe_* inputs.
- Reset mid-operation: all pending entries are lost; no write is issued for them.

Decomposition:
- Shared package: register-number width (5), data width (32), and the r0 constant (5'd0).
- One natural sub-module, wbq_match: given entry arrays, head and count plus one lookup register, returns hit and youngest data. Instantiate it twice (ports A and B).

Test Plan:
- Reset with clrn low mid-cycle -> count=0, enq_ready=1, hit_a=0; a write previously queued to r5 is never issued.
- Enqueue (r3,0x11),(r4,0x22) with pipe idle -> we=1 with wn=3,d=0x11 then wn=4,d=0x22 on consecutive cycles; count returns to 0.
- Fill 4 entries while pipe_we=1 continuously -> enq_ready=0, 5th push dropped. Release pipe -> 4 drains in order, then count=0.
- Queue (r7,0xA),(r7,0xB) -> rna=7 gives hit_a=1, qa_fwd=0xB. rnb=0 gives hit_b=0.
- Queue (r9,0x55), then pipe write r9=0x99 -> the drained entry shows we=0; hit on r9 becomes 0 after the kill posedge.
- enq_wn=0 with enq_we=1 -> count unchanged, no we pulse.

Source files
------------

// File: rtl/wb_write_queue_pkg.sv
// wb_write_queue_pkg: shared widths, the r0 constant and the pending-write entry layout
package wb_write_queue_pkg;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam logic [RW-1:0] R0 = 5'd0;
  typedef struct packed {
    logic          v;
    logic [RW-1:0] wn;
    logic [DW-1:0] d;
  } entry_t;
endpackage

// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: enqueue, pipeline writeback, register-file write and lookup signals
interface wb_write_queue_if #(parameter int AW = 2);
  import wb_write_queue_pkg::*;
  logic          enq_we;
  logic [RW-1:0] enq_wn;
  logic [DW-1:0] enq_d;
  logic          enq_ready;
  logic          pipe_we;
  logic [RW-1:0] pipe_wn;
  logic [DW-1:0] pipe_d;
  logic          we;
  logic [RW-1:0] wn;
  logic [DW-1:0] d;
  logic [RW-1:0] rna;
  logic [RW-1:0] rnb;
  logic          hit_a;
  logic [DW-1:0] qa_fwd;
  logic          hit_b;
  logic [DW-1:0] qb_fwd;
  logic [AW:0]   count;
  modport master (
    output enq_we, enq_wn, enq_d, pipe_we, pipe_wn, pipe_d, rna, rnb,
    input  enq_ready, we, wn, d, hit_a, qa_fwd, hit_b, qb_fwd, count
  );
  modport slave (
    input  enq_we, enq_wn, enq_d, pipe_we, pipe_wn, pipe_d, rna, rnb,
    output enq_ready, we, wn, d, hit_a, qa_fwd, hit_b, qb_fwd, count
  );
endinterface

// File: rtl/wb_write_queue_match.sv
// wbq_match: finds the youngest occupied valid entry targeting one lookup register
module wbq_match import wb_write_queue_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  entry_t [DEPTH-1:0] ents_i,
  input  logic [AW-1:0]      head_i,
  input  logic [AW:0]        count_i,
  input  logic [RW-1:0]      rn_i,
  output logic               hit_o,
  output logic [DW-1:0]      data_o
);
  localparam int CW = AW + 1;
  // walk oldest to youngest so the last match seen is the youngest one
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_i && rn_i != R0 && ents_i[head_i + AW'(i)].v &&
          ents_i[head_i + AW'(i)].wn == rn_i) begin
        hit_o  = 1'b1;
        data_o = ents_i[head_i + AW'(i)].d;
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: FIFO of pending long-latency register writes drained into idle writeback slots
module wb_write_queue import wb_write_queue_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            clrn,
  wb_write_queue_if.slave bus
);
  localparam int CW = AW + 1;
  entry_t [DEPTH-1:0] ents_q, ents_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic full, push, pop, kill;
  assign full          = count_q == CW'(DEPTH);
  assign push          = bus.enq_we && !full && bus.enq_wn != R0;
  assign pop           = !bus.pipe_we && count_q != '0;
  assign kill          = bus.pipe_we && bus.pipe_wn != R0;
  assign bus.enq_ready = !full;
  assign bus.count     = count_q;
  // kill older writes to the pipe's register, then allocate the new entry so it survives
  always_comb begin
    ents_d = ents_q;
    for (int i = 0; i < DEPTH; i++)
      if (kill && ents_q[i].wn == bus.pipe_wn) ents_d[i].v = 1'b0;
    if (push) ents_d[tail_q] = '{v: 1'b1, wn: bus.enq_wn, d: bus.enq_d};
    head_d  = pop ? head_q + AW'(1) : head_q;
    tail_d  = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  // queue state; reset drops every pending entry
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ents_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ents_q  <= ents_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // pipeline writeback owns the port; otherwise the head drains, killed heads with we=0
  always_comb begin
    bus.we = bus.pipe_we ? 1'b1 : (count_q != '0) ? ents_q[head_q].v : 1'b0;
    bus.wn = bus.pipe_we ? bus.pipe_wn : (count_q != '0) ? ents_q[head_q].wn : R0;
    bus.d  = bus.pipe_we ? bus.pipe_d : (count_q != '0) ? ents_q[head_q].d : '0;
  end
  wbq_match #(.DEPTH(DEPTH), .AW(AW)) u_match_a (
    .ents_i(ents_q), .head_i(head_q), .count_i(count_q), .rn_i(bus.rna),
    .hit_o(bus.hit_a), .data_o(bus.qa_fwd)
  );
  wbq_match #(.DEPTH(DEPTH), .AW(AW)) u_match_b (
    .ents_i(ents_q), .head_i(head_q), .count_i(count_q), .rn_i(bus.rnb),
    .hit_o(bus.hit_b), .data_o(bus.qb_fwd)
  );
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed scenarios plus random traffic against a queue-based model
module tb_wb_write_queue;
  localparam int DEPTH = 4;
  typedef struct { logic v; logic [4:0] wn; logic [31:0] d; } ment_t;
  logic clk = 1'b0;
  logic clrn;
  int errs = 0;
  int checks = 0;
  ment_t mq[$];
  wb_write_queue_if #(.AW(2)) bus();
  wb_write_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .clrn(clrn), .bus(bus.slave));
  always #5 clk = ~clk;

  // advance one posedge and apply the same edge to the model
  task automatic tick();
    bit push, pop;
    @(posedge clk);
    push = bus.enq_we && mq.size() < DEPTH && bus.enq_wn != 5'd0;
    pop  = !bus.pipe_we && mq.size() != 0;
    if (clrn) begin
      if (bus.pipe_we && bus.pipe_wn != 5'd0)
        foreach (mq[i]) if (mq[i].wn == bus.pipe_wn) mq[i].v = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{1'b1, bus.enq_wn, bus.enq_d});
    end
    #1;
  endtask

  function automatic logic exp_we();
    return bus.pipe_we ? 1'b1 : mq.size() != 0 ? mq[0].v : 1'b0;
  endfunction
  function automatic logic [4:0] exp_wn();
    return bus.pipe_we ? bus.pipe_wn : mq.size() != 0 ? mq[0].wn : 5'd0;
  endfunction
  function automatic logic [31:0] exp_d();
    return bus.pipe_we ? bus.pipe_d : mq.size() != 0 ? mq[0].d : 32'd0;
  endfunction
  function automatic logic [32:0] look(logic [4:0] rn);
    logic [32:0] r = '0;
    if (rn != 5'd0) foreach (mq[i]) if (mq[i].v && mq[i].wn == rn) r = {1'b1, mq[i].d};
    return r;
  endfunction

  task automatic idle();
    bus.enq_we = 0; bus.enq_wn = 0; bus.enq_d = 0;
    bus.pipe_we = 0; bus.pipe_wn = 0; bus.pipe_d = 0;
    bus.rna = 0; bus.rnb = 0;
  endtask

  task automatic test_reset();
    idle();
    clrn = 1'b0;
    bus.pipe_we = 1; bus.pipe_wn = 5'd6; bus.pipe_d = 32'h66;
    #1;
    checks++; if (bus.count !== 3'd0) begin errs++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    checks++; if (bus.enq_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b exp 1", bus.enq_ready); end
    checks++; if (bus.hit_a !== 1'b0 || bus.qa_fwd !== 32'd0) begin errs++; $display("FAIL rst_hit got %b/%h exp 0/0", bus.hit_a, bus.qa_fwd); end
    checks++; if ({bus.we, bus.wn, bus.d} !== {1'b1, 5'd6, 32'h66}) begin errs++; $display("FAIL rst_passthru got %b/%0d/%h exp 1/6/66", bus.we, bus.wn, bus.d); end
    tick();
    clrn = 1'b1;
    bus.enq_we = 1; bus.enq_wn = 5'd5; bus.enq_d = 32'h55;
    tick();
    bus.enq_we = 0; bus.rna = 5'd5;
    #1;
    checks++; if (bus.hit_a !== 1'b1 || bus.qa_fwd !== 32'h55) begin errs++; $display("FAIL pre_rst_hit got %b/%h exp 1/55", bus.hit_a, bus.qa_fwd); end
    #2;
    clrn = 1'b0;
    mq.delete();
    #1;
    checks++; if (bus.count !== 3'd0 || bus.enq_ready !== 1'b1) begin errs++; $display("FAIL midrst got count %0d ready %b exp 0/1", bus.count, bus.enq_ready); end
    checks++; if (bus.hit_a !== 1'b0) begin errs++; $display("FAIL midrst_hit got %b exp 0", bus.hit_a); end
    tick();
    clrn = 1'b1;
    bus.pipe_we = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.we !== 1'b0) begin errs++; $display("FAIL lost_write cyc %0d got we %b exp 0", i, bus.we); end
      tick();
    end
  endtask

  task automatic test_drain();
    idle();
    bus.enq_we = 1; bus.enq_wn = 5'd3; bus.enq_d = 32'h11;
    tick();
    bus.enq_wn = 5'd4; bus.enq_d = 32'h22;
    #1;
    checks++; if ({bus.we, bus.wn, bus.d} !== {1'b1, 5'd3, 32'h11}) begin errs++; $display("FAIL drain0 got %b/%0d/%h exp 1/3/11", bus.we, bus.wn, bus.d); end
    tick();
    bus.enq_we = 0;
    #1;
    checks++; if ({bus.we, bus.wn, bus.d} !== {1'b1, 5'd4, 32'h22}) begin errs++; $display("FAIL drain1 got %b/%0d/%h exp 1/4/22", bus.we, bus.wn, bus.d); end
    tick();
    checks++; if (bus.count !== 3'd0 || bus.we !== 1'b0) begin errs++; $display("FAIL drain_end got count %0d we %b exp 0/0", bus.count, bus.we); end
  endtask

  task automatic test_fill();
    idle();
    bus.pipe_we = 1;
    for (int i = 0; i < 5; i++) begin
      bus.enq_we = 1; bus.enq_wn = 5'(10 + i); bus.enq_d = 32'(32'h100 + i);
      tick();
      if (i == 3) begin
        checks++; if (bus.enq_ready !== 1'b0 || bus.count !== 3'd4) begin errs++; $display("FAIL full got ready %b count %0d exp 0/4", bus.enq_ready, bus.count); end
      end
    end
    checks++; if (bus.count !== 3'd4) begin errs++; $display("FAIL drop5 got count %0d exp 4", bus.count); end
    bus.enq_we = 0; bus.pipe_we = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({bus.we, bus.wn, bus.d} !== {1'b1, 5'(10 + i), 32'(32'h100 + i)}) begin errs++; $display("FAIL fill_drain%0d got %b/%0d/%h exp 1/%0d/%h", i, bus.we, bus.wn, bus.d, 10 + i, 32'h100 + i); end
      tick();
    end
    checks++; if (bus.count !== 3'd0) begin errs++; $display("FAIL fill_end got count %0d exp 0", bus.count); end
  endtask

  task automatic test_lookup();
    idle();
    bus.pipe_we = 1;
    bus.enq_we = 1; bus.enq_wn = 5'd7; bus.enq_d = 32'hA;
    tick();
    bus.enq_d = 32'hB;
    tick();
    bus.enq_we = 0; bus.rna = 5'd7; bus.rnb = 5'd0;
    #1;
    checks++; if (bus.hit_a !== 1'b1 || bus.qa_fwd !== 32'hB) begin errs++; $display("FAIL youngest got %b/%h exp 1/b", bus.hit_a, bus.qa_fwd); end
    checks++; if (bus.hit_b !== 1'b0 || bus.qb_fwd !== 32'd0) begin errs++; $display("FAIL r0_lookup got %b/%h exp 0/0", bus.hit_b, bus.qb_fwd); end
    bus.pipe_we = 0;
    tick();
    tick();
    checks++; if (bus.count !== 3'd0) begin errs++; $display("FAIL lookup_end got count %0d exp 0", bus.count); end
  endtask

  task automatic test_kill();
    idle();
    bus.pipe_we = 1;
    bus.enq_we = 1; bus.enq_wn = 5'd9; bus.enq_d = 32'h55;
    tick();
    bus.rna = 5'd9;
    bus.pipe_wn = 5'd9; bus.pipe_d = 32'h99;
    bus.enq_d = 32'h77;
    #1;
    checks++; if (bus.hit_a !== 1'b1 || bus.qa_fwd !== 32'h55) begin errs++; $display("FAIL prekill got %b/%h exp 1/55", bus.hit_a, bus.qa_fwd); end
    checks++; if ({bus.we, bus.wn, bus.d} !== {1'b1, 5'd9, 32'h99}) begin errs++; $display("FAIL pipe_prio got %b/%0d/%h exp 1/9/99", bus.we, bus.wn, bus.d); end
    tick();
    bus.enq_we = 0; bus.pipe_we = 0;
    #1;
    checks++; if (bus.count !== 3'd2 || bus.we !== 1'b0) begin errs++; $display("FAIL killed_head got count %0d we %b exp 2/0", bus.count, bus.we); end
    checks++; if (bus.hit_a !== 1'b1 || bus.qa_fwd !== 32'h77) begin errs++; $display("FAIL kill_enq got %b/%h exp 1/77", bus.hit_a, bus.qa_fwd); end
    tick();
    checks++; if ({bus.we, bus.wn, bus.d} !== {1'b1, 5'd9, 32'h77}) begin errs++; $display("FAIL survivor got %b/%0d/%h exp 1/9/77", bus.we, bus.wn, bus.d); end
    tick();
    checks++; if (bus.hit_a !== 1'b0 || bus.count !== 3'd0) begin errs++; $display("FAIL kill_end got hit %b count %0d exp 0/0", bus.hit_a, bus.count); end
  endtask

  task automatic test_r0();
    idle();
    bus.enq_we = 1; bus.enq_wn = 5'd0; bus.enq_d = 32'hDEAD;
    tick();
    bus.enq_we = 0;
    #1;
    checks++; if (bus.count !== 3'd0 || bus.we !== 1'b0) begin errs++; $display("FAIL r0_enq got count %0d we %b exp 0/0", bus.count, bus.we); end
  endtask

  task automatic test_random();
    logic [32:0] la, lb;
    for (int c = 0; c < 400; c++) begin
      bus.enq_we = $urandom_range(0, 2) != 0;
      bus.enq_wn = 5'($urandom_range(0, 7));
      bus.enq_d = $urandom;
      bus.pipe_we = $urandom_range(0, 2) == 0;
      bus.pipe_wn = 5'($urandom_range(0, 7));
      bus.pipe_d = $urandom;
      bus.rna = 5'($urandom_range(0, 7));
      bus.rnb = 5'($urandom_range(0, 7));
      #1;
      la = look(bus.rna);
      lb = look(bus.rnb);
      checks++; if (bus.we !== exp_we()) begin errs++; $display("FAIL rnd_we c%0d got %b exp %b", c, bus.we, exp_we()); end
      checks++; if (bus.wn !== exp_wn()) begin errs++; $display("FAIL rnd_wn c%0d got %0d exp %0d", c, bus.wn, exp_wn()); end
      checks++; if (bus.d !== exp_d()) begin errs++; $display("FAIL rnd_d c%0d got %h exp %h", c, bus.d, exp_d()); end
      checks++; if (bus.count !== 3'(mq.size())) begin errs++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, bus.count, mq.size()); end
      checks++; if (bus.enq_ready !== (mq.size() != DEPTH)) begin errs++; $display("FAIL rnd_ready c%0d got %b exp %b", c, bus.enq_ready, mq.size() != DEPTH); end
      checks++; if ({bus.hit_a, bus.qa_fwd} !== la) begin errs++; $display("FAIL rnd_a c%0d got %b/%h exp %b/%h", c, bus.hit_a, bus.qa_fwd, la[32], la[31:0]); end
      checks++; if ({bus.hit_b, bus.qb_fwd} !== lb) begin errs++; $display("FAIL rnd_b c%0d got %b/%h exp %b/%h", c, bus.hit_b, bus.qb_fwd, lb[32], lb[31:0]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_fill();
    test_lookup();
    test_kill();
    test_r0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
